// File: rtl/sysmon_drp_pkg.sv
// Shared constants for the SYSMON DRP responder: register map, FSM state
// encoding, min/max reset values and the measurement justification helper.
package sysmon_drp_pkg;

    localparam logic [6:0] ADDR_TEMP     = 7'h00;
    localparam logic [6:0] ADDR_VCCINT   = 7'h01;
    localparam logic [6:0] ADDR_VCCAUX   = 7'h02;
    localparam logic [6:0] ADDR_MMRST    = 7'h03;
    localparam logic [6:0] ADDR_MAXT     = 7'h20;
    localparam logic [6:0] ADDR_MINT     = 7'h24;
    localparam logic [6:0] ADDR_CFG_BASE = 7'h40;

    localparam logic [15:0] MAX_RST = 16'h0000;
    localparam logic [15:0] MIN_RST = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // 10-bit ADC codes are presented MSB-aligned in the 16-bit registers.
    function automatic logic [15:0] ljust(input logic [9:0] code);
        return {code, 6'b0};
    endfunction

endpackage

// File: rtl/sysmon_minmax.sv
// Min/max temperature tracker.
//   clk, rst    : clock, synchronous active-high reset
//   meas_valid  : new measurement present this cycle
//   meas_temp   : 10-bit temperature code
//   clr         : reset min/max (wins over a same-edge measurement)
//   max_temp    : largest temperature seen (left-justified)
//   min_temp    : smallest temperature seen (left-justified)
module sysmon_minmax
    import sysmon_drp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        meas_valid,
    input  logic [9:0]  meas_temp,
    input  logic        clr,
    output logic [15:0] max_temp,
    output logic [15:0] min_temp
);

    logic [15:0] max_q, max_d;
    logic [15:0] min_q, min_d;
    logic [15:0] t_new;

    always_comb begin
        max_d = max_q;
        min_d = min_q;
        t_new = ljust(meas_temp);
        if (clr) begin
            max_d = MAX_RST;
            min_d = MIN_RST;
        end else if (meas_valid) begin
            if (t_new > max_q) max_d = t_new;
            if (t_new < min_q) min_d = t_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_q <= MAX_RST;
            min_q <= MIN_RST;
        end else begin
            max_q <= max_d;
            min_q <= min_d;
        end
    end

    assign max_temp = max_q;
    assign min_temp = min_q;

endmodule

// File: rtl/sysmon_drp_responder.sv
// DRP slave fronting a SYSMON-style register map.
//   clk, rst        : clock, synchronous active-high reset
//   DADDR_IN/DEN_IN/DWE_IN/DI_IN : DRP request (one per DEN_IN high cycle)
//   DO_OUT/DRDY_OUT : read data and one-cycle completion strobe,
//                     LATENCY cycles after the request cycle
//   meas_*          : measurement set, captured when meas_valid is high
//   overrun         : sticky flag, a request arrived while busy
// Reads sample and writes commit on the edge that raises DRDY_OUT.
module sysmon_drp_responder
    import sysmon_drp_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  DADDR_IN,
    input  logic        DEN_IN,
    input  logic        DWE_IN,
    input  logic [15:0] DI_IN,
    output logic [15:0] DO_OUT,
    output logic        DRDY_OUT,
    input  logic        meas_valid,
    input  logic [9:0]  meas_temp,
    input  logic [9:0]  meas_vccint,
    input  logic [9:0]  meas_vccaux,
    output logic        overrun
);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [6:0]  addr_q, addr_d;
    logic        we_q, we_d;
    logic [15:0] di_q, di_d;
    logic [15:0] do_q, do_d;
    logic        ovr_q, ovr_d;
    logic [15:0] temp_q, temp_d, vint_q, vint_d, vaux_q, vaux_d;
    logic [15:0] cfg_q [16];
    logic [15:0] cfg_d [16];

    // Transaction actually completing this edge (the live inputs when
    // LATENCY is 1, otherwise the latched request).
    logic        commit;
    logic [6:0]  cm_addr;
    logic        cm_we;
    logic [15:0] cm_di;
    logic        mm_clr;
    logic [15:0] max_temp, min_temp;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        di_d    = di_q;
        do_d    = do_q;
        ovr_d   = ovr_q;
        cfg_d   = cfg_q;
        commit  = 1'b0;
        cm_addr = addr_q;
        cm_we   = we_q;
        cm_di   = di_q;
        mm_clr  = 1'b0;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (DEN_IN) begin
                    addr_d = DADDR_IN;
                    we_d   = DWE_IN;
                    di_d   = DI_IN;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                        cm_addr = DADDR_IN;
                        cm_we   = DWE_IN;
                        cm_di   = DI_IN;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Requests while busy are dropped, only flagged.
                if (DEN_IN) ovr_d = 1'b1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (commit) begin
            if (cm_we) begin
                if (cm_addr[6:4] == ADDR_CFG_BASE[6:4]) cfg_d[cm_addr[3:0]] = cm_di;
                if (cm_addr == ADDR_MMRST) mm_clr = 1'b1;
            end else begin
                if (cm_addr[6:4] == ADDR_CFG_BASE[6:4]) begin
                    do_d = cfg_q[cm_addr[3:0]];
                end else begin
                    case (cm_addr)
                        ADDR_TEMP:   do_d = temp_q;
                        ADDR_VCCINT: do_d = vint_q;
                        ADDR_VCCAUX: do_d = vaux_q;
                        ADDR_MAXT:   do_d = max_temp;
                        ADDR_MINT:   do_d = min_temp;
                        default:     do_d = 16'h0000;
                    endcase
                end
            end
        end

        temp_d = meas_valid ? ljust(meas_temp)   : temp_q;
        vint_d = meas_valid ? ljust(meas_vccint) : vint_q;
        vaux_d = meas_valid ? ljust(meas_vccaux) : vaux_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 7'd0;
            we_q    <= 1'b0;
            di_q    <= 16'h0000;
            do_q    <= 16'h0000;
            ovr_q   <= 1'b0;
            temp_q  <= 16'h0000;
            vint_q  <= 16'h0000;
            vaux_q  <= 16'h0000;
            for (int i = 0; i < 16; i++) cfg_q[i] <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            di_q    <= di_d;
            do_q    <= do_d;
            ovr_q   <= ovr_d;
            temp_q  <= temp_d;
            vint_q  <= vint_d;
            vaux_q  <= vaux_d;
            for (int i = 0; i < 16; i++) cfg_q[i] <= cfg_d[i];
        end
    end

    sysmon_minmax u_minmax (
        .clk        (clk),
        .rst        (rst),
        .meas_valid (meas_valid),
        .meas_temp  (meas_temp),
        .clr        (mm_clr),
        .max_temp   (max_temp),
        .min_temp   (min_temp)
    );

    assign DRDY_OUT = (state_q == ST_RESP);
    assign DO_OUT   = do_q;
    assign overrun  = ovr_q;

endmodule

// File: doc/sysmon_drp_responder.md
SYSMON_DRP_RESPONDER -- requirements
Module: sysmon_drp_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from accepted DEN_IN to DRDY_OUT pulse; legal range 1..15.
REQ-002 SHALL have one clock, clk; reset is synchronous and active-high, rst.
REQ-003 SHALL have ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- DADDR_IN  in  7  DRP address
- DEN_IN  in  1  DRP enable, one request per high cycle
- DWE_IN  in  1  1 = write, 0 = read; qualified by DEN_IN
- DI_IN  in  16  DRP write data
- DO_OUT  out  16  DRP read data
- DRDY_OUT  out  1  one-cycle completion strobe
- meas_valid  in  1  new measurement set present
- meas_temp  in  10  temperature code
- meas_vccint  in  10  VCCINT code
- meas_vccaux  in  10  VCCAUX code
- overrun  out  1  sticky: DEN_IN seen while busy

Function
REQ-004 SHALL implement FSM IDLE, BUSY, RESP; reset state IDLE.
REQ-005 SHALL, in IDLE or RESP with DEN_IN=1, latch DADDR_IN/DWE_IN/DI_IN, load the latency counter, and enter BUSY (RESP then IDLE if LATENCY=1).
REQ-006 SHALL assert DRDY_OUT for exactly one cycle, at cycle t+LATENCY for a request accepted at cycle t (state RESP).
REQ-007 SHALL, in RESP with DEN_IN=0, return to IDLE; back-to-back requests give one completion per LATENCY cycles.
REQ-008 SHALL ignore DEN_IN in BUSY (no state, counter, or register change) and set overrun=1 until rst.
REQ-009 SHALL load DO_OUT on the edge that raises DRDY_OUT for reads, from register contents before that edge; DO_OUT holds its value otherwise, including across writes.
REQ-010 SHALL commit writes on the edge that raises DRDY_OUT.
REQ-011 SHALL use this address map, with measurements left-justified ({code,6'b0}):
- 0x00 TEMP (RO)
- 0x01 VCCINT (RO)
- 0x02 VCCAUX (RO)
- 0x03 write-only: any write resets min/max; reads 0x0000
- 0x20 MAX_TEMP (RO)
- 0x24 MIN_TEMP (RO)
- 0x40..0x4F CFG[0..15] (RW, 16x16)
- all other addresses read 0x0000; writes there are ignored
REQ-012 SHALL, on meas_valid=1, update TEMP/VCCINT/VCCAUX; set MAX_TEMP to the new TEMP if strictly greater (unsigned); set MIN_TEMP to the new TEMP if strictly less.
REQ-013 SHALL give a 0x03 write priority over a meas_valid update committing on the same edge, so min/max end at their reset values.
REQ-014 SHALL make a meas_valid update on the DRDY edge invisible to that read; the next read returns the new value.
REQ-015 SHALL keep CFG writes and meas_valid updates independent when both occur on the same edge.

Reset
REQ-016 SHALL, on rst: state IDLE, DRDY_OUT=0, DO_OUT=0x0000, overrun=0, TEMP/VCCINT/VCCAUX=0x0000, MAX_TEMP=0x0000, MIN_TEMP=0xFFFF, CFG[0..15]=0x0000.
REQ-017 SHALL, on rst during BUSY or RESP, abandon the pending request: no DRDY_OUT pulse and no write commit.
REQ-018 SHALL give rst priority over DEN_IN and meas_valid on the same edge.

Structure
REQ-019 SHALL place address constants (ADDR_TEMP, ADDR_VCCINT, ADDR_VCCAUX, ADDR_MMRST, ADDR_MAXT, ADDR_MINT, ADDR_CFG_BASE), state encoding, and the MIN/MAX reset values in package sysmon_drp_pkg.
REQ-020 SHALL implement min/max tracking, including the reset-on-0x03 input, as sub-module sysmon_minmax.

Verification
REQ-021 Read latency: LATENCY=4; DEN_IN=1 with DADDR_IN=0x00 at cycle 10 after meas_valid with meas_temp=0x2A5 -> DRDY_OUT=1 at cycle 14 only, DO_OUT=0xA940.
REQ-022 CFG round trip: write 0x1234 to 0x45, then read 0x45 -> DO_OUT=0x1234; read 0x50 -> DO_OUT=0x0000; write 0xFFFF to 0x00, then read 0x00 -> TEMP unchanged.
REQ-023 Overrun: DEN_IN at cycle t and again at t+2 (LATENCY=4) -> one DRDY_OUT at t+4, second request dropped, overrun=1.
REQ-024 Min/max: meas_temp sequence 0x100, 0x300, 0x080 -> MAX_TEMP=0xC000, MIN_TEMP=0x2000; write 0x03 with meas_valid on the same edge -> MAX_TEMP=0x0000, MIN_TEMP=0xFFFF.
REQ-025 Back-to-back: LATENCY=1; DEN_IN held high for 3 cycles with reads of 0x40..0x42 -> DRDY_OUT high 3 consecutive cycles, correct data each cycle, overrun=0.
REQ-026 Reset mid-request: write 0xBEEF to 0x41 accepted, rst at t+2 -> no DRDY_OUT pulse; a later read of 0x41 returns 0x0000.
